// File: rtl/joy_conditioner.sv
// Joystick line conditioner: 2-FF sync, ms-tick debounce and per-fire-button autofire.
// Optional build macro JOY_SOCD_CLEAN_EN neutralises opposing directions pressed together.
module joy_conditioner #(
  parameter int CLKMHZ           = 16,
  parameter int DEBOUNCE_MS      = 3,
  parameter int AUTOFIRE_HALF_MS = 50
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] joy_in,
  input  logic [1:0] autofire_en,
  output logic [5:0] joy_out,
  output logic       tick_ms
);

  localparam int              TICK_CYC  = CLKMHZ * 1000;
  localparam int              PW        = $clog2(TICK_CYC);
  localparam logic [PW-1:0]   TICK_LAST = PW'(TICK_CYC - 1);
  localparam logic [3:0]      DB_N      = 4'(DEBOUNCE_MS);
  localparam logic [7:0]      AF_N      = 8'(AUTOFIRE_HALF_MS);

  typedef enum logic [1:0] {AF_IDLE, AF_ON, AF_OFF} af_state_t;

  logic [5:0]    sync1;
  logic [5:0]    raw;
  logic [PW-1:0] pre_cnt;
  logic [5:0]    deb;
  logic [3:0]    deb_cnt [6];
  logic [3:0]    dir_clean;
  logic [3:0]    dir_q;
  logic [1:0]    fire_q;
  af_state_t     af_state [2];
  logic [7:0]    af_phase [2];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '1;
      raw   <= '1;
    end else begin
      sync1 <= joy_in;
      raw   <= sync1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                 pre_cnt <= '0;
    else if (pre_cnt == TICK_LAST) pre_cnt <= '0;
    else                          pre_cnt <= pre_cnt + 1'b1;
  end

  assign tick_ms = (pre_cnt == TICK_LAST);

  // Any sample equal to the debounced state restarts the stability count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb <= '1;
      for (int i = 0; i < 6; i++) deb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 6; i++) begin
        if (raw[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (tick_ms) begin
          if (deb_cnt[i] + 4'd1 == DB_N) begin
            deb[i]     <= raw[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + 4'd1;
          end
        end
      end
    end
  end

  always_comb begin
    dir_clean = deb[3:0];
`ifdef JOY_SOCD_CLEAN_EN
    if (!deb[0] && !deb[1]) dir_clean[1:0] = 2'b11;
    if (!deb[2] && !deb[3]) dir_clean[3:2] = 2'b11;
`endif
  end

  // Autofire FSMs: leaving ON/OFF reloads the output from the debounced line,
  // so a release or disable never leaves the button stuck pressed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dir_q  <= '1;
      fire_q <= '1;
      for (int i = 0; i < 2; i++) begin
        af_state[i] <= AF_IDLE;
        af_phase[i] <= '0;
      end
    end else begin
      dir_q <= dir_clean;
      for (int i = 0; i < 2; i++) begin
        case (af_state[i])
          AF_IDLE: begin
            fire_q[i]   <= deb[4+i];
            af_phase[i] <= '0;
            if (!deb[4+i] && autofire_en[i]) begin
              af_state[i] <= AF_ON;
              fire_q[i]   <= 1'b0;
            end
          end
          AF_ON, AF_OFF: begin
            if (deb[4+i] || !autofire_en[i]) begin
              af_state[i] <= AF_IDLE;
              af_phase[i] <= '0;
              fire_q[i]   <= deb[4+i];
            end else if (tick_ms) begin
              if (af_phase[i] + 8'd1 == AF_N) begin
                af_phase[i] <= '0;
                if (af_state[i] == AF_ON) begin
                  af_state[i] <= AF_OFF;
                  fire_q[i]   <= 1'b1;
                end else begin
                  af_state[i] <= AF_ON;
                  fire_q[i]   <= 1'b0;
                end
              end else begin
                af_phase[i] <= af_phase[i] + 8'd1;
              end
            end
          end
          default: begin
            af_state[i] <= AF_IDLE;
            af_phase[i] <= '0;
            fire_q[i]   <= 1'b1;
          end
        endcase
      end
    end
  end

  assign joy_out = {fire_q, dir_q};

endmodule
